// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings, response payload and size helpers for the data-memory
// arbiter and its load extender.
package data_mem_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BSEL_W  = DATA_W / 8;
    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [SIZE_W-1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef struct packed {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] err;
        logic [DATA_W-1:0]  rdata;
    } rsp_t;

    // Byte lanes touched by an access of the given size (LSB-aligned).
    function automatic logic [BSEL_W-1:0] size_to_bsel(input logic [SIZE_W-1:0] size);
        logic [BSEL_W-1:0] bsel;
        case (size)
            SZ_BYTE: bsel = 4'b0001;
            SZ_HALF: bsel = 4'b0011;
            SZ_WORD: bsel = 4'b1111;
            default: bsel = 4'b0000;
        endcase
        return bsel;
    endfunction

    // Number of bytes covered; illegal size reports a full word so the
    // range check stays conservative.
    function automatic logic [2:0] size_to_bytes(input logic [SIZE_W-1:0] size);
        logic [2:0] nbytes;
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_load_ext.sv
// Combinational load lane select and zero/sign extension; shared with the
// instruction-side fetch path.
module data_mem_load_ext
    import data_mem_arbiter_pkg::*;
(
    input  logic [SIZE_W-1:0] size_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_c_o
);

    always_comb begin
        data_c_o = data_i;
        case (size_i)
            SZ_BYTE: data_c_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
            SZ_HALF: data_c_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
            default: data_c_o = data_i;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter with bounded lock in front of the
// byte-addressed data memory; responses return one cycle after acceptance.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            m_req_i,
    input  logic [1:0]            m_we_i,
    input  logic [1:0]            m_lock_i,
    input  logic [1:0]            m_signed_i,
    input  logic [3:0]            m_size_i,
    input  logic [2*ADDR_W-1:0]   m_addr_i,
    input  logic [63:0]           m_wdata_i,
    output logic [1:0]            m_gnt_o,
    output logic [1:0]            m_rvalid_o,
    output logic [1:0]            m_err_o,
    output logic [31:0]           m_rdata_o,
    output logic                  mem_write_o,
    output logic [3:0]            mem_b_sel_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i
);

    localparam int unsigned EXT_W = ADDR_W + 1;

    logic             rr_ptr_q, rr_ptr_d;
    logic             own_vld_q, own_vld_d;
    logic             own_q, own_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] lock_next;
    rsp_t             rsp_q, rsp_d;

    logic              gnt_any;
    logic              gnt_idx;
    logic              sel_we;
    logic              sel_lock;
    logic              sel_signed;
    logic [SIZE_W-1:0] sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [EXT_W-1:0]  end_addr;
    logic              sel_err;
    logic [31:0]       ld_data;

    // Winner: live lock owner, else pointed requester, else the other one.
    always_comb begin
        gnt_any = 1'b1;
        gnt_idx = rr_ptr_q;
        if (own_vld_q && m_req_i[own_q]) begin
            gnt_idx = own_q;
        end else if (m_req_i[rr_ptr_q]) begin
            gnt_idx = rr_ptr_q;
        end else if (m_req_i[~rr_ptr_q]) begin
            gnt_idx = ~rr_ptr_q;
        end else begin
            gnt_any = 1'b0;
        end
    end

    assign m_gnt_o = {gnt_any & gnt_idx, gnt_any & ~gnt_idx};

    assign sel_we     = m_we_i[gnt_idx];
    assign sel_lock   = m_lock_i[gnt_idx];
    assign sel_signed = m_signed_i[gnt_idx];
    assign sel_size   = gnt_idx ? m_size_i[3:2] : m_size_i[1:0];
    assign sel_addr   = gnt_idx ? m_addr_i[2*ADDR_W-1:ADDR_W] : m_addr_i[ADDR_W-1:0];
    assign sel_wdata  = gnt_idx ? m_wdata_i[63:32] : m_wdata_i[31:0];

    // Last byte of the access computed one bit wider to catch running off the top.
    always_comb begin
        end_addr = {1'b0, sel_addr} + EXT_W'(size_to_bytes(sel_size)) - EXT_W'(1);
        sel_err  = (sel_size == SZ_ILL) || end_addr[ADDR_W];
    end

    always_comb begin
        mem_write_o = gnt_any & sel_we & ~sel_err;
        mem_b_sel_o = (gnt_any && !sel_err) ? size_to_bsel(sel_size) : 4'b0000;
        mem_addr_o  = gnt_any ? sel_addr : '0;
        mem_data_o  = gnt_any ? sel_wdata : '0;
    end

    data_mem_load_ext u_load_ext (
        .size_i   (sel_size),
        .signed_i (sel_signed),
        .data_i   (mem_data_i),
        .data_c_o (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= 1'b0;
            own_vld_q  <= 1'b0;
            own_q      <= 1'b0;
            lock_cnt_q <= '0;
            rsp_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            own_vld_q  <= own_vld_d;
            own_q      <= own_d;
            lock_cnt_q <= lock_cnt_d;
            rsp_q      <= rsp_d;
        end
    end

    // Response capture plus lock/round-robin bookkeeping for the accepted beat.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        own_vld_d  = own_vld_q;
        own_d      = own_q;
        lock_cnt_d = lock_cnt_q;
        lock_next  = '0;
        rsp_d      = '0;

        if (gnt_any) begin
            rsp_d.valid[gnt_idx] = 1'b1;
            rsp_d.err[gnt_idx]   = sel_err;
            rsp_d.rdata          = (sel_err || sel_we) ? '0 : ld_data;

            if (sel_lock) begin
                lock_next = ((own_vld_q && (own_q == gnt_idx)) ? lock_cnt_q : '0) + CNT_W'(1);
                if (lock_next >= CNT_W'(MAX_LOCK)) begin
                    own_vld_d  = 1'b0;
                    lock_cnt_d = '0;
                    rr_ptr_d   = ~gnt_idx;
                end else begin
                    own_vld_d  = 1'b1;
                    own_d      = gnt_idx;
                    lock_cnt_d = lock_next;
                end
            end else begin
                own_vld_d  = 1'b0;
                lock_cnt_d = '0;
                rr_ptr_d   = ~gnt_idx;
            end
        end else begin
            // No request at all, so any owner has dropped its request.
            own_vld_d  = 1'b0;
            lock_cnt_d = '0;
        end
    end

    assign m_rvalid_o = rsp_q.valid;
    assign m_err_o    = rsp_q.err;
    assign m_rdata_o  = rsp_q.rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised scoreboard bench for data_mem_arbiter with a byte-array memory
// and a rule-level arbitration/response model.
module tb_data_mem_arbiter;

    localparam int ADDR_W    = 13;
    localparam int MAX_LOCK  = 8;
    localparam int MEM_BYTES = 1 << ADDR_W;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [1:0]          m_req_i, m_we_i, m_lock_i, m_signed_i;
    logic [3:0]          m_size_i;
    logic [2*ADDR_W-1:0] m_addr_i;
    logic [63:0]         m_wdata_i;
    logic [1:0]          m_gnt_o, m_rvalid_o, m_err_o;
    logic [31:0]         m_rdata_o;
    logic                mem_write_o;
    logic [3:0]          mem_b_sel_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [31:0]         mem_data_o;
    logic [31:0]         mem_data_i;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_lock_i(m_lock_i),
        .m_signed_i(m_signed_i), .m_size_i(m_size_i), .m_addr_i(m_addr_i),
        .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_err_o(m_err_o), .m_rdata_o(m_rdata_o), .mem_write_o(mem_write_o),
        .mem_b_sel_o(mem_b_sel_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          vld;
        bit          we;
        bit          lock;
        bit          sgn;
        bit [1:0]    size;
        int unsigned addr;
        bit [31:0]   wdata;
    } txn_t;

    typedef struct {
        int        who;
        bit        err;
        bit [31:0] rdata;
    } exp_t;

    int        n_checks = 0;
    int        n_fail   = 0;
    txn_t      cur [2];
    exp_t      sbq [$];
    logic [7:0] dmem    [MEM_BYTES];
    bit   [7:0] ref_mem [MEM_BYTES];
    int        ptr, owner, streak;

    function automatic bit [7:0] init_byte(input int i);
        return 8'(i * 13 + 7) ^ 8'(i >> 5);
    endfunction

    // Device-side memory: lane-masked asynchronous read, byte-enabled write.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) dmem[i] = init_byte(i);
        forever begin
            @(posedge clk_i);
            if (mem_write_o)
                for (int i = 0; i < 4; i++)
                    if (mem_b_sel_o[i]) dmem[int'(mem_addr_o) + i] <= mem_data_o[8*i +: 8];
        end
    end

    always_comb begin
        mem_data_i = '0;
        for (int i = 0; i < 4; i++)
            if (mem_b_sel_o[i]) mem_data_i[8*i +: 8] = dmem[(int'(mem_addr_o) + i) % MEM_BYTES];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit we, input bit lock, input bit sgn, input bit [1:0] size,
                                input int unsigned addr, input bit [31:0] wdata);
        txn_t t;
        t.vld = 1'b1; t.we = we; t.lock = lock; t.sgn = sgn;
        t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t idle_txn();
        txn_t t;
        t = mk(1'b0, 1'b0, 1'b0, 2'd0, 0, 32'h0);
        t.vld = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int r;
        int unsigned a;
        r = $urandom_range(0, 15);
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(MEM_BYTES - 6, MEM_BYTES - 1)
                                        : $urandom_range(0, 31);
        return mk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  (r == 0) ? 2'd3 : 2'(r % 3), a, $urandom);
    endfunction

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            m_req_i[n]                  = cur[n].vld;
            m_we_i[n]                   = cur[n].we;
            m_lock_i[n]                 = cur[n].lock;
            m_signed_i[n]               = cur[n].sgn;
            m_size_i[2*n +: 2]          = cur[n].size;
            m_addr_i[ADDR_W*n +: ADDR_W] = ADDR_W'(cur[n].addr);
            m_wdata_i[32*n +: 32]       = cur[n].wdata;
        end
    endtask

    // One cycle: drive, predict winner and memory drive, push expected response.
    task automatic step(output int acc);
        int        w, nb;
        bit        err;
        bit [31:0] val;
        bit [3:0]  bsel;
        @(negedge clk_i);
        drive();
        #1;
        w = -1;
        if (owner >= 0 && cur[owner].vld) w = owner;
        else if (cur[ptr].vld)            w = ptr;
        else if (cur[1 - ptr].vld)        w = 1 - ptr;
        acc = w;
        check("gnt", 32'(m_gnt_o), (w < 0) ? 32'd0 : ((w == 0) ? 32'd1 : 32'd2));
        if (w < 0) begin
            check("idle_bsel", 32'(mem_b_sel_o), 32'd0);
            check("idle_write", 32'(mem_write_o), 32'd0);
            owner  = -1;
            streak = 0;
        end else begin
            nb   = (cur[w].size == 2'd0) ? 1 : (cur[w].size == 2'd1) ? 2 : 4;
            err  = (cur[w].size == 2'd3) || (cur[w].addr + nb > MEM_BYTES);
            bsel = err ? 4'h0 : ((nb == 1) ? 4'h1 : (nb == 2) ? 4'h3 : 4'hF);
            check("bsel", 32'(mem_b_sel_o), 32'(bsel));
            check("write", 32'(mem_write_o), 32'(cur[w].we && !err));
            if (!err) begin
                check("addr", 32'(mem_addr_o), cur[w].addr);
                if (cur[w].we) check("wdata", mem_data_o, cur[w].wdata);
            end
            val = 32'h0;
            if (!err) begin
                for (int i = 0; i < nb; i++) begin
                    if (cur[w].we) ref_mem[cur[w].addr + i] = cur[w].wdata[8*i +: 8];
                    else           val[8*i +: 8] = ref_mem[cur[w].addr + i];
                end
                if (!cur[w].we && cur[w].sgn && nb < 4 && val[8*nb - 1])
                    val = val | (32'hFFFF_FFFF << (8 * nb));
                if (cur[w].we) val = 32'h0;
            end
            sbq.push_back('{who: w, err: err, rdata: val});
            if (cur[w].lock) begin
                streak = (owner == w) ? streak + 1 : 1;
                if (streak >= MAX_LOCK) begin
                    owner = -1; streak = 0; ptr = 1 - w;
                end else begin
                    owner = w;
                end
            end else begin
                owner = -1; streak = 0; ptr = 1 - w;
            end
            cur[w].vld = 1'b0;
        end
    endtask

    // Response monitor: every visible response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (m_rvalid_o != 2'b00) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 32'(m_rvalid_o), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_valid", 32'(m_rvalid_o), (e.who == 0) ? 32'd1 : 32'd2);
                    check("rsp_err", 32'(m_err_o), e.err ? ((e.who == 0) ? 32'd1 : 32'd2) : 32'd0);
                    check("rsp_rdata", m_rdata_o, e.rdata);
                end
            end else if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rsp_missing", 32'(m_rvalid_o), (e.who == 0) ? 32'd1 : 32'd2);
            end
        end
    end

    initial begin
        int acc;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        ptr = 0; owner = -1; streak = 0;
        cur[0] = idle_txn(); cur[1] = idle_txn();
        rst_ni = 1'b0;
        drive();
        #2;
        check("reset_rvalid", 32'(m_rvalid_o), 32'd0);
        check("reset_err", 32'(m_err_o), 32'd0);
        check("reset_rdata", m_rdata_o, 32'd0);
        check("reset_gnt", 32'(m_gnt_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Both requesters stream word reads: grants must alternate.
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 2; n++)
                if (!cur[n].vld) cur[n] = mk(1'b0, 1'b0, 1'b0, 2'd2, 4 * $urandom_range(0, 60), 32'h0);
            step(acc);
        end
        cur[0] = idle_txn(); cur[1] = idle_txn();
        step(acc);
        step(acc);

        // Byte write then signed and unsigned read-back.
        cur[0] = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'h1234_5680);
        step(acc);
        cur[0] = mk(1'b0, 1'b0, 1'b1, 2'd0, 32'h10, 32'h0);
        step(acc);
        cur[0] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0);
        step(acc);

        // Requester 1 locks while requester 0 waits.
        cur[1] = mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        step(acc);
        cur[0] = mk(1'b0, 1'b0, 1'b1, 2'd1, 32'h12, 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(acc);
            if (acc == 1) cur[1] = mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h20 + 4 * k, 32'h0);
        end
        cur[0] = idle_txn(); cur[1] = idle_txn();
        step(acc);

        // Out-of-range half write, illegal size, then confirm the top byte is untouched.
        cur[0] = mk(1'b1, 1'b0, 1'b0, 2'd1, 32'h1FFF, 32'hA5A5_5A5A);
        step(acc);
        cur[0] = mk(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0);
        step(acc);
        cur[1] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h1FFF, 32'h0);
        step(acc);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            step(acc);
            for (int n = 0; n < 2; n++)
                if (!cur[n].vld && $urandom_range(0, 9) < 7) cur[n] = rand_txn();
        end
        cur[0] = idle_txn(); cur[1] = idle_txn();
        step(acc);
        step(acc);

        // Asynchronous reset while a read response is showing.
        cur[0] = mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'hDEAD_BEEF);
        step(acc);
        cur[0] = mk(1'b0, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0);
        step(acc);
        @(posedge clk_i);
        #2;
        check("pre_rst_rvalid", 32'(m_rvalid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_rvalid", 32'(m_rvalid_o), 32'd0);
        check("async_rst_rdata", m_rdata_o, 32'd0);
        sbq.delete();
        ptr = 0; owner = -1; streak = 0;
        #1;
        rst_ni = 1'b1;
        cur[0] = mk(1'b0, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0);
        cur[1] = mk(1'b0, 1'b0, 1'b0, 2'd2, 32'h44, 32'h0);
        step(acc);
        step(acc);
        cur[0] = idle_txn(); cur[1] = idle_txn();
        step(acc);
        step(acc);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
